// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared widths, state encoding, ALU opcode and magnitude helper
package mult_seq_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam logic [3:0] OPER_AND = 4'b0000;
  localparam logic [3:0] OPER_OR  = 4'b0001;
  localparam logic [3:0] OPER_XOR = 4'b0010;
  localparam logic [3:0] OPER_ADD = 4'b0100;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FIX = 2'b10, DONE = 2'b11} state_t;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s & v[WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/mult_seq_if.sv
// mult_seq_if: request/response bundle between execute stage and multiplier
interface mult_seq_if;
  import mult_seq_pkg::*;
  logic start;
  logic signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  modport master(output start, signed_op, a, b, input busy, done, prod_hi, prod_lo);
  modport slave(input start, signed_op, a, b, output busy, done, prod_hi, prod_lo);
endinterface

// File: rtl/alu.sv
// alu: 16-bit logic/add unit with optional operand inversion and carry-in
module alu
  import mult_seq_pkg::*;
(
  input  logic [3:0]       oper,
  input  logic             cin,
  input  logic             inv_a,
  input  logic             inv_b,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  logic [WIDTH-1:0] x_a, x_b;
  logic [WIDTH:0] s;
  // operand conditioning, result select and overflow (signed or unsigned view)
  always_comb begin
    x_a = inv_a ? ~a : a;
    x_b = inv_b ? ~b : b;
    s = {1'b0, x_a} + {1'b0, x_b} + {{WIDTH{1'b0}}, cin};
    y = oper == OPER_ADD ? s[WIDTH-1:0] :
        oper == OPER_AND ? x_a & x_b :
        oper == OPER_OR  ? x_a | x_b : x_a ^ x_b;
    ovf = (oper == OPER_ADD) & (sign ? (x_a[WIDTH-1] == x_b[WIDTH-1]) & (s[WIDTH-1] != x_a[WIDTH-1]) : s[WIDTH]);
  end
endmodule

// File: rtl/mult_seq_fsm.sv
// mult_seq_fsm: sequencing state, iteration count and registered busy/done
module mult_seq_fsm
  import mult_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  output state_t state,
  output logic   busy,
  output logic   done,
  output logic   accept
);
  logic [CNT_W-1:0] count;
  assign accept = start & ~busy;
  // IDLE/DONE accept a request, RUN iterates WIDTH times, FIX writes the product
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= state == FIX;
      unique case (state)
        IDLE, DONE: begin
          state <= start ? RUN : IDLE;
          busy  <= start;
          count <= '0;
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/mult_seq.sv
// mult_seq: shift-add sequential multiplier reusing one ALU adder per cycle
module mult_seq
  import mult_seq_pkg::*;
(
  input logic       clk,
  input logic       rst,
  mult_seq_if.slave bus
);
  state_t state;
  logic accept, neg, carry, alu_ovf_unused;
  logic [WIDTH-1:0] mag_a, acc_hi, q, sum;
  mult_seq_fsm u_fsm (
    .clk(clk), .rst(rst), .start(bus.start), .state(state),
    .busy(bus.busy), .done(bus.done), .accept(accept)
  );
  alu u_alu (
    .oper(OPER_ADD), .cin(1'b0), .inv_a(1'b0), .inv_b(1'b0), .sign(1'b0),
    .a(acc_hi), .b(mag_a), .y(sum), .ovf(alu_ovf_unused)
  );
  assign carry = sum < acc_hi;
  // operand capture, one shift-add step per RUN cycle, sign fix-up into the product
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a       <= '0;
      acc_hi      <= '0;
      q           <= '0;
      neg         <= 1'b0;
      bus.prod_hi <= '0;
      bus.prod_lo <= '0;
    end else if (accept) begin
      mag_a  <= mag(bus.a, bus.signed_op);
      q      <= mag(bus.b, bus.signed_op);
      neg    <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      acc_hi <= '0;
    end else if (state == RUN) begin
      {acc_hi, q} <= q[0] ? {carry, sum, q[WIDTH-1:1]} : {1'b0, acc_hi, q[WIDTH-1:1]};
    end else if (state == FIX) begin
      {bus.prod_hi, bus.prod_lo} <= neg ? -{acc_hi, q} : {acc_hi, q};
    end
  end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed and random checks of mult_seq against an arithmetic reference
module tb_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  mult_seq_if bus();
  mult_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint p;
    p = s ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
    return p[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] xa, input logic [15:0] xb, input logic s, output int lat);
    bus.a = xa;
    bus.b = xb;
    bus.signed_op = s;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic op(input string tag, input logic [15:0] xa, input logic [15:0] xb, input logic s);
    int lat;
    go(xa, xb, s, lat);
    check({tag, "_lat"}, lat, 17);
    check({tag, "_prod"}, {bus.prod_hi, bus.prod_lo}, ref_mul(xa, xb, s));
    step();
    check({tag, "_pulse"}, {31'd0, bus.done}, 0);
  endtask

  initial begin
    int lat;
    int dones;
    logic [31:0] prev;
    logic [15:0] ra, rb;
    logic rs;
    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    step();
    step();
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_prod", {bus.prod_hi, bus.prod_lo}, 0);
    rst = 1'b0;
    step();
    // small unsigned with busy tracking
    bus.a = 16'h0003;
    bus.b = 16'h0005;
    bus.signed_op = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 17; i++) begin
      dones += int'(bus.busy);
      step();
    end
    check("u3x5_busy_cycles", dones, 17);
    check("u3x5_done", {31'd0, bus.done}, 1);
    check("u3x5_prod", {bus.prod_hi, bus.prod_lo}, 32'h0000_000F);
    step();
    op("umax", 16'hFFFF, 16'hFFFF, 1'b0);
    check("umax_const", {bus.prod_hi, bus.prod_lo}, 32'hFFFE_0001);
    op("s_m3x5", 16'hFFFD, 16'h0005, 1'b1);
    check("s_m3x5_const", {bus.prod_hi, bus.prod_lo}, 32'hFFFF_FFF1);
    op("s_min", 16'h8000, 16'h8000, 1'b1);
    check("s_min_const", {bus.prod_hi, bus.prod_lo}, 32'h4000_0000);
    op("zero_neg", 16'h0000, 16'h8123, 1'b1);
    // start while busy is ignored; product holds until FIX
    prev = {bus.prod_hi, bus.prod_lo};
    bus.a = 16'd7;
    bus.b = 16'd9;
    bus.signed_op = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    check("rej_hold", {bus.prod_hi, bus.prod_lo}, prev);
    check("rej_busy", {31'd0, bus.busy}, 1);
    bus.a = 16'h1234;
    bus.b = 16'h1234;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 5;
    while (!bus.done && lat < 40) begin
      step();
      lat++;
    end
    check("rej_lat", lat, 17);
    check("rej_prod", {bus.prod_hi, bus.prod_lo}, 32'h0000_003F);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      dones += int'(bus.done);
    end
    check("rej_no_second", dones, 0);
    // reset mid-run
    bus.a = 16'h00FF;
    bus.b = 16'h0101;
    bus.signed_op = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, bus.busy}, 0);
    check("mid_rst_done", {31'd0, bus.done}, 0);
    check("mid_rst_prod", {bus.prod_hi, bus.prod_lo}, 0);
    op("after_rst", 16'd2, 16'd2, 1'b0);
    // back-to-back: second start issued in the done cycle
    go(16'd6, 16'd7, 1'b0, lat);
    check("b2b1_lat", lat, 17);
    check("b2b1_prod", {bus.prod_hi, bus.prod_lo}, 32'd42);
    go(16'hFFFF, 16'h0002, 1'b1, lat);
    check("b2b2_lat", lat, 17);
    check("b2b2_prod", {bus.prod_hi, bus.prod_lo}, 32'hFFFF_FFFE);
    step();
    // random operands and signedness
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      go(ra, rb, rs, lat);
      check("rnd_lat", lat, 17);
      check("rnd_prod", {bus.prod_hi, bus.prod_lo}, ref_mul(ra, rb, rs));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
